// File: rtl/io_mem_slave.sv
// io_mem_slave: bus-cycle slave for an 8086-style multiplexed bus.
//
// Latches address, space and chip select while ALE is high, decodes a
// base/size window and runs the access with a fixed number of wait states.
// READY is pulled low while wait states are inserted. Read data is
// registered and is qualified by DOUT_EN.
//
// Ports:
//   CLK      bus clock, rising edge
//   RESET_N  asynchronous active-low reset
//   ALE      address latch enable (only looked at in IDLE)
//   Address  byte address, valid with ALE
//   IOM      space select, sampled with ALE
//   CS_N     active-low chip select, sampled with ALE
//   BHE_N    active-low byte-high enable (16-bit builds only)
//   RD_N     active-low read strobe
//   WR_N     active-low write strobe
//   DIN      write data, taken in XFER
//   DOUT     registered read data
//   DOUT_EN  high while DOUT carries valid read data
//   READY    low inserts a wait state
//   ERR      one-cycle pulse on a protocol error
module io_mem_slave #(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 20,
  parameter int          DEPTH       = 1024,
  parameter int unsigned BASE_ADDR   = 'h0,
  parameter int          WAIT_STATES = 1,
  parameter bit          IO_SPACE    = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ALE,
  input  logic [ADDR_W-1:0] Address,
  input  logic              IOM,
  input  logic              CS_N,
  input  logic              BHE_N,
  input  logic              RD_N,
  input  logic              WR_N,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_EN,
  output logic              READY,
  output logic              ERR
);

  localparam int LANES = DATA_W / 8;
  localparam int SHIFT = (DATA_W == 16) ? 1 : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE_ADDR + DEPTH * LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_XFER,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  index;
  logic              a0;
  logic              bhe_lat;
  logic              is_write;
  logic [3:0]        wait_cnt;

  logic              hit;
  logic [ADDR_W:0]   addr_ext;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  addr_index;
  logic [LANES-1:0]  lane_en;

  logic latch_en;
  logic dir_set;
  logic err_set;
  logic cnt_load;
  logic cnt_dec;
  logic strobe_released;

  // Window decode; the extra top bit keeps the upper bound from wrapping.
  always_comb begin
    addr_ext   = {1'b0, Address};
    offset     = Address - WIN_LO[ADDR_W-1:0];
    addr_index = IDX_W'(offset >> SHIFT);
    hit        = !CS_N && (IOM == IO_SPACE) &&
                 (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  end

  // Byte lanes: an 8-bit build has one always-enabled lane; a 16-bit build
  // enables the low lane on even addresses and the high lane on BHE_N=0.
  always_comb begin
    lane_en = '1;
    if (DATA_W == 16) begin
      lane_en[0]       = !a0;
      lane_en[LANES-1] = !bhe_lat;
    end
  end

  assign strobe_released = is_write ? WR_N : RD_N;
  assign READY           = (state != S_WAIT);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state and control strobes for the datapath.
  always_comb begin
    next_state = state;
    latch_en   = 1'b0;
    dir_set    = 1'b0;
    err_set    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ALE && hit) begin
          latch_en   = 1'b1;
          next_state = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!RD_N && !WR_N) begin
          err_set    = 1'b1;
          next_state = S_IDLE;
        end else if (!RD_N || !WR_N) begin
          dir_set = 1'b1;
          if (WAIT_STATES > 0) begin
            cnt_load   = 1'b1;
            next_state = S_WAIT;
          end else begin
            next_state = S_XFER;
          end
        end
      end
      S_WAIT: begin
        if (strobe_released) begin
          err_set    = 1'b1;
          next_state = S_IDLE;
        end else if (wait_cnt == 4'd0) begin
          next_state = S_XFER;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_XFER: next_state = S_DONE;
      S_DONE: begin
        if (RD_N && WR_N) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Latched cycle context, wait counter, error pulse and read data.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      index    <= '0;
      a0       <= 1'b0;
      bhe_lat  <= 1'b1;
      is_write <= 1'b0;
      wait_cnt <= 4'd0;
      ERR      <= 1'b0;
      DOUT     <= '0;
      DOUT_EN  <= 1'b0;
    end else begin
      ERR <= err_set;
      if (latch_en) begin
        index   <= addr_index;
        a0      <= Address[0];
        bhe_lat <= BHE_N;
      end
      if (dir_set) is_write <= !WR_N;
      if (cnt_load)     wait_cnt <= 4'(WAIT_STATES - 1);
      else if (cnt_dec) wait_cnt <= wait_cnt - 4'd1;
      if (state == S_XFER && !is_write) begin
        DOUT    <= mem[index];
        DOUT_EN <= 1'b1;
      end
      if (state == S_DONE && next_state == S_IDLE) DOUT_EN <= 1'b0;
    end
  end

  // Storage is never reset; writes happen only in XFER, so a cycle aborted
  // by reset or by a protocol error leaves the array untouched.
  always_ff @(posedge CLK) begin
    if (state == S_XFER && is_write) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_en[l]) mem[index][l*8 +: 8] <= DIN[l*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_io_mem_slave.sv
// tb_io_mem_slave: self-checking bench for io_mem_slave.
//
// Three slaves share one bus, each with its own chip select:
//   0: 8-bit,  base 0x100, 1 wait state, I/O space
//   1: 16-bit, base 0x200, 3 wait states, I/O space
//   2: 8-bit,  base 0x300, 0 wait states, memory space
// Expected read data comes from a bench-side memory model and is queued
// when a read is issued, then popped when DOUT_EN rises.
module tb_io_mem_slave;

  logic        clk;
  logic        rst_n;
  logic        ale;
  logic [19:0] addr;
  logic        iom;
  logic [2:0]  cs_n;
  logic        bhe_n;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] din;

  logic [7:0]  dout0;
  logic [15:0] dout1;
  logic [7:0]  dout2;
  logic [2:0]  en_v;
  logic [2:0]  rdy_v;
  logic [2:0]  err_v;

  logic [15:0] model [3][16];
  logic [15:0] exp_q [$];

  int passes = 0;
  int total  = 0;

  io_mem_slave #(.DATA_W(8), .ADDR_W(20), .DEPTH(16), .BASE_ADDR('h100),
                 .WAIT_STATES(1), .IO_SPACE(1'b1)) u_s0 (
    .CLK(clk), .RESET_N(rst_n), .ALE(ale), .Address(addr), .IOM(iom),
    .CS_N(cs_n[0]), .BHE_N(bhe_n), .RD_N(rd_n), .WR_N(wr_n), .DIN(din[7:0]),
    .DOUT(dout0), .DOUT_EN(en_v[0]), .READY(rdy_v[0]), .ERR(err_v[0]));

  io_mem_slave #(.DATA_W(16), .ADDR_W(20), .DEPTH(16), .BASE_ADDR('h200),
                 .WAIT_STATES(3), .IO_SPACE(1'b1)) u_s1 (
    .CLK(clk), .RESET_N(rst_n), .ALE(ale), .Address(addr), .IOM(iom),
    .CS_N(cs_n[1]), .BHE_N(bhe_n), .RD_N(rd_n), .WR_N(wr_n), .DIN(din),
    .DOUT(dout1), .DOUT_EN(en_v[1]), .READY(rdy_v[1]), .ERR(err_v[1]));

  io_mem_slave #(.DATA_W(8), .ADDR_W(20), .DEPTH(16), .BASE_ADDR('h300),
                 .WAIT_STATES(0), .IO_SPACE(1'b0)) u_s2 (
    .CLK(clk), .RESET_N(rst_n), .ALE(ale), .Address(addr), .IOM(iom),
    .CS_N(cs_n[2]), .BHE_N(bhe_n), .RD_N(rd_n), .WR_N(wr_n), .DIN(din[7:0]),
    .DOUT(dout2), .DOUT_EN(en_v[2]), .READY(rdy_v[2]), .ERR(err_v[2]));

  // Free-running 10-unit bus clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] doutOf(input int sel);
    case (sel)
      0:       return {8'h00, dout0};
      1:       return dout1;
      default: return {8'h00, dout2};
    endcase
  endfunction

  function automatic int waitsOf(input int sel);
    case (sel)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int idxOf(input int sel, input logic [19:0] a);
    case (sel)
      0:       return int'(a - 20'h100);
      1:       return int'((a - 20'h200) >> 1);
      default: return int'(a - 20'h300);
    endcase
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    total++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    else
      passes++;
  endtask

  // Address phase: ALE for one cycle, leaving the slave in ADDR.
  task automatic startCycle(input int sel, input logic [19:0] a,
                            input logic iom_v, input logic bhe,
                            input logic cs_act);
    @(negedge clk);
    ale   = 1'b1;
    addr  = a;
    iom   = iom_v;
    bhe_n = bhe;
    cs_n  = cs_act ? ~(3'b001 << sel) : 3'b111;
    @(negedge clk);
    ale  = 1'b0;
    cs_n = 3'b111;
  endtask

  // Complete read or write access with wait-state and latency checks.
  task automatic applyStimulus(input int sel, input logic [19:0] a,
                               input logic iom_v, input logic bhe,
                               input logic is_wr, input logic [15:0] data);
    int ws;
    int low;
    int lat;
    int idx;
    logic [15:0] expv;
    ws  = waitsOf(sel);
    idx = idxOf(sel, a);
    low = 0;
    lat = 0;
    startCycle(sel, a, iom_v, bhe, 1'b1);
    if (is_wr) begin
      din  = data;
      wr_n = 1'b0;
    end else begin
      rd_n = 1'b0;
      exp_q.push_back(sel == 1 ? model[1][idx] : {8'h00, model[sel][idx][7:0]});
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!rdy_v[sel]) low++;
      if (!is_wr && en_v[sel]) begin
        lat = k;
        break;
      end
      if (is_wr && k == ws + 2) break;
    end
    checkOutput("ready low cycles", 16'(low), 16'(ws));
    if (!is_wr) begin
      expv = exp_q.pop_front();
      checkOutput("read latency", 16'(lat), 16'(ws + 2));
      if (lat != 0) checkOutput("read data", doutOf(sel), expv);
    end
    rd_n = 1'b1;
    wr_n = 1'b1;
    @(negedge clk);
    if (!is_wr) checkOutput("dout_en cleared", {15'd0, en_v[sel]}, 16'd0);
    if (is_wr) begin
      if (sel == 1) begin
        if (!a[0]) model[1][idx][7:0]  = data[7:0];
        if (!bhe)  model[1][idx][15:8] = data[15:8];
      end else begin
        model[sel][idx][7:0] = data[7:0];
      end
    end
  endtask

  // Decode miss: the slave must not react to the following write strobe.
  task automatic applyMiss(input string tag, input logic [19:0] a,
                           input logic iom_v, input logic cs_act);
    int act;
    act = 0;
    startCycle(0, a, iom_v, 1'b1, cs_act);
    din  = 16'h0011;
    wr_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (!rdy_v[0] || en_v[0] || err_v[0]) act++;
    end
    checkOutput(tag, 16'(act), 16'd0);
    wr_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ale   = 1'b0;
    addr  = '0;
    iom   = 1'b1;
    cs_n  = 3'b111;
    bhe_n = 1'b1;
    rd_n  = 1'b1;
    wr_n  = 1'b1;
    din   = '0;
    #22;
    checkOutput("reset ready0", {15'd0, rdy_v[0]}, 16'd1);
    checkOutput("reset en0",    {15'd0, en_v[0]},  16'd0);
    checkOutput("reset err0",   {15'd0, err_v[0]}, 16'd0);
    checkOutput("reset dout0",  doutOf(0),         16'd0);
    checkOutput("reset ready1", {15'd0, rdy_v[1]}, 16'd1);
    checkOutput("reset dout1",  doutOf(1),         16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 8-bit slave: basic write/read, window edges.
    applyStimulus(0, 20'h105, 1'b1, 1'b1, 1'b1, 16'h00A5);
    applyStimulus(0, 20'h105, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(0, 20'h100, 1'b1, 1'b1, 1'b1, 16'h005A);
    applyStimulus(0, 20'h10F, 1'b1, 1'b1, 1'b1, 16'h003C);
    applyStimulus(0, 20'h10F, 1'b1, 1'b1, 1'b0, 16'h0000);

    // Decode misses leave storage alone.
    applyMiss("miss cs_n high", 20'h105, 1'b1, 1'b0);
    applyMiss("miss iom",       20'h105, 1'b0, 1'b1);
    applyMiss("miss above top", 20'h110, 1'b1, 1'b1);
    applyStimulus(0, 20'h105, 1'b1, 1'b1, 1'b0, 16'h0000);
    applyStimulus(0, 20'h100, 1'b1, 1'b1, 1'b0, 16'h0000);

    // Both strobes low in ADDR.
    begin
      int errs;
      errs = 0;
      startCycle(0, 20'h105, 1'b1, 1'b1, 1'b1);
      din  = 16'h0099;
      rd_n = 1'b0;
      wr_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (err_v[0]) errs++;
      end
      checkOutput("both strobes err pulses", 16'(errs), 16'd1);
      rd_n = 1'b1;
      wr_n = 1'b1;
      @(negedge clk);
    end
    applyStimulus(0, 20'h105, 1'b1, 1'b1, 1'b0, 16'h0000);

    // 16-bit slave: byte lanes.
    applyStimulus(1, 20'h204, 1'b1, 1'b0, 1'b1, 16'h1234);
    applyStimulus(1, 20'h205, 1'b1, 1'b0, 1'b1, 16'hFF77);
    applyStimulus(1, 20'h204, 1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1, 20'h206, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    applyStimulus(1, 20'h207, 1'b1, 1'b1, 1'b1, 16'h0000);
    applyStimulus(1, 20'h206, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Write strobe dropped during the second wait state.
    begin
      int errs;
      errs = 0;
      startCycle(1, 20'h204, 1'b1, 1'b0, 1'b1);
      din  = 16'h0000;
      wr_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("2nd wait ready", {15'd0, rdy_v[1]}, 16'd0);
      wr_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (err_v[1]) errs++;
      end
      checkOutput("released strobe err pulses", 16'(errs), 16'd1);
    end
    applyStimulus(1, 20'h204, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Zero-wait memory-space slave.
    applyStimulus(2, 20'h305, 1'b0, 1'b1, 1'b1, 16'h0077);
    applyStimulus(2, 20'h305, 1'b0, 1'b1, 1'b0, 16'h0000);

    // Asynchronous reset in the middle of a write's wait states.
    startCycle(1, 20'h206, 1'b1, 1'b0, 1'b1);
    din  = 16'h1111;
    wr_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset ready", {15'd0, rdy_v[1]}, 16'd1);
    checkOutput("async reset en",    {15'd0, en_v[1]},  16'd0);
    checkOutput("async reset err",   {15'd0, err_v[1]}, 16'd0);
    checkOutput("async reset dout",  doutOf(1),         16'd0);
    wr_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 20'h206, 1'b1, 1'b0, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Hard time limit so the bench never hangs.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
